// File: rtl/gpio_port.sv
// Parametrised bidirectional GPIO bank: per-pin direction, synchronised inputs,
// atomic set/clear of the output register and rise/fall edge interrupts.
module gpio_port #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] OE_RESET    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_OE      = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_OUT_SET = 3'd3;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd4;
    localparam logic [2:0] ADDR_RISE_EN = 3'd5;
    localparam logic [2:0] ADDR_FALL_EN = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [ARM_W-1:0] r_arm;
    logic [31:0]      r_rdata;
    logic             r_rvalid;
    logic             r_irq;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_in;
    logic             w_armed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_nxt;
    logic [31:0]      w_rd_data;

    // Bus handshake: sel qualifies an access. sel&we writes at this clock edge;
    // sel&~we latches rdata and pulses rvalid for exactly one cycle. The slave
    // never stalls, so every access is accepted on the cycle it is presented.
    assign w_wr    = sel & we;
    assign w_rd    = sel & ~we;
    assign w_wdata = wdata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^wdata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_in;
        end
    end

    assign w_in = r_sync[SYNC_STAGES-1];

    // Edges stay masked until the chain has flushed the reset zeros, so pins
    // that are already high when reset releases do not look like rising edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 1'b1;
        end
    end

    assign w_armed = (r_arm == ARM_W'(ARM_MAX));
    assign w_rise  = w_in & ~r_prev;
    assign w_fall  = ~w_in & r_prev;
    assign w_event = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out     <= OUT_RESET;
            r_oe      <= OE_RESET;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (addr)
                ADDR_OUT:     r_out     <= w_wdata;
                ADDR_OE:      r_oe      <= w_wdata;
                ADDR_OUT_SET: r_out     <= r_out | w_wdata;
                ADDR_OUT_CLR: r_out     <= r_out & ~w_wdata;
                ADDR_RISE_EN: r_rise_en <= w_wdata;
                ADDR_FALL_EN: r_fall_en <= w_wdata;
                default:      ;
            endcase
        end
    end

    // A new edge in the same cycle as a W1C clear wins: the set term is OR-ed last.
    assign w_clr        = (w_wr && (addr == ADDR_STATUS)) ? w_wdata : '0;
    assign w_status_nxt = (r_status & ~w_clr) | w_event;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= w_status_nxt;
            r_irq    <= |w_status_nxt;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_OUT, ADDR_OUT_SET, ADDR_OUT_CLR: w_rd_data[WIDTH-1:0] = r_out;
            ADDR_OE:      w_rd_data[WIDTH-1:0] = r_oe;
            ADDR_IN:      w_rd_data[WIDTH-1:0] = w_in;
            ADDR_RISE_EN: w_rd_data[WIDTH-1:0] = r_rise_en;
            ADDR_FALL_EN: w_rd_data[WIDTH-1:0] = r_fall_en;
            ADDR_STATUS:  w_rd_data[WIDTH-1:0] = r_status;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign gpio_o  = r_out;
    assign gpio_oe = r_oe;
    assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed register/edge/reset scenarios followed by a
// randomised register and pin sequence checked against a register-level model.
module tb_gpio_port;

    localparam int W    = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sel = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          rvalid;
    logic [W-1:0]  gpio_i = '0;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_status, m_pins;

    gpio_port #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .OUT_RESET('0), .OE_RESET('0)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_status = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [W-1:0] v;
        case (a)
            3'd0, 3'd3, 3'd4: v = m_out;
            3'd1:    v = m_oe;
            3'd2:    v = m_pins;
            3'd5:    v = m_rise;
            3'd6:    v = m_fall;
            default: v = m_status;
        endcase
        return {24'h0, v};
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        bus_write(a, d);
        case (a)
            3'd0: m_out = d[W-1:0];
            3'd1: m_oe = d[W-1:0];
            3'd3: m_out = m_out | d[W-1:0];
            3'd4: m_out = m_out & ~d[W-1:0];
            3'd5: m_rise = d[W-1:0];
            3'd6: m_fall = d[W-1:0];
            3'd7: m_status = m_status & ~d[W-1:0];
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, input string tag);
        exp_q.push_back(model_read(a));
        sel = 1'b1; we = 1'b0; addr = a;
        tick(1);
        sel = 1'b0;
        check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic check_pads(input string tag);
        check({tag, "_gpio_o"}, {24'h0, gpio_o}, {24'h0, m_out});
        check({tag, "_gpio_oe"}, {24'h0, gpio_oe}, {24'h0, m_oe});
        check({tag, "_irq"}, {31'h0, irq}, {31'h0, |m_status});
    endtask

    // Pins change, then the bench waits long enough for any edge to settle.
    task automatic set_pins(input logic [W-1:0] v);
        logic [W-1:0] ev;
        ev = (v & ~m_pins & m_rise) | (~v & m_pins & m_fall);
        gpio_i = v;
        tick(SYNC + 3);
        m_status = m_status | ev;
        m_pins = v;
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        int op;

        model_reset();
        gpio_i = 8'hFF;
        m_pins = 8'hFF;
        #2;
        check_pads("reset");
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);
        tick(3);
        rst = 1'b1;
        do_write(3'd5, 32'hFF);
        tick(10);
        bus_read(3'd7, "no_spurious_status");
        check_pads("no_spurious");
        bus_read(3'd0, "rd_out_reset");
        bus_read(3'd1, "rd_oe_reset");
        bus_read(3'd2, "rd_in_high");

        do_write(3'd0, 32'hA5);
        do_write(3'd3, 32'h0A);
        do_write(3'd4, 32'h81);
        check("gpio_o_2e", {24'h0, gpio_o}, 32'h2E);
        bus_read(3'd0, "rd_out_2e");
        bus_read(3'd3, "rd_set_alias");
        bus_read(3'd4, "rd_clr_alias");
        do_write(3'd2, 32'h55);
        bus_read(3'd2, "in_write_ignored");

        do_write(3'd5, 32'h01);
        do_write(3'd6, 32'h00);
        set_pins(8'h00);
        bus_read(3'd7, "fall_disabled");
        gpio_i = 8'h01;
        tick(SYNC);
        check("irq_before_edge", {31'h0, irq}, 32'h0);
        tick(2);
        check("irq_after_edge", {31'h0, irq}, 32'h1);
        tick(2);
        m_pins = 8'h01;
        m_status = 8'h01;
        bus_read(3'd7, "rise_status");
        set_pins(8'h00);
        bus_read(3'd7, "fall_keeps_status");

        gpio_i = 8'h01;
        tick(SYNC);
        bus_write(3'd7, 32'h01);
        check("collide_irq", {31'h0, irq}, 32'h1);
        tick(2);
        m_pins = 8'h01;
        bus_read(3'd7, "collide_status");
        do_write(3'd7, 32'h01);
        check_pads("w1c_clear");

        set_pins(8'h00);
        set_pins(8'h01);
        do_write(3'd5, 32'h00);
        bus_read(3'd7, "disable_keeps_status");
        do_write(3'd7, 32'hFF);
        check_pads("clear_all");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 6) begin
                ra = 3'($urandom_range(0, 6));
                do_write(ra, $urandom);
            end else if (op == 7) begin
                do_write(3'd7, 32'($urandom_range(0, 255)));
            end else if (op == 8) begin
                set_pins(W'($urandom_range(0, 255)));
            end else begin
                ra = 3'($urandom_range(0, 7));
                bus_read(ra, "rand_read");
            end
            check_pads("rand");
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), "rand_final_read");
        end

        do_write(3'd0, 32'h3C);
        do_write(3'd1, 32'hFF);
        do_write(3'd5, 32'h01);
        set_pins(8'h00);
        set_pins(8'h01);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'hFF;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_pads("async_reset");
        tick(2);
        sel = 1'b0; we = 1'b0;
        rst = 1'b1;
        check("post_reset_rdata", rdata, 32'h0);
        check("post_reset_rvalid", {31'h0, rvalid}, 32'h0);
        tick(8);
        bus_read(3'd0, "no_write_landed");
        bus_read(3'd7, "post_reset_status");
        check_pads("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
